// File: rtl/tessia_fetch_pkg.sv
// rtl/tessia_fetch_pkg.sv - shared types and constants for the instruction prefetch queue
package tessia_fetch_pkg;

  // Request sequencer states: idle, waiting on a live request, waiting on a request to discard
  typedef enum logic [1:0] {IDLE, WAIT, DROP} pf_state_t;

  // Distance between consecutive instruction words
  localparam logic [31:0] PC_STEP = 32'd4;

  // One queued instruction together with the address it was fetched from
  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } pf_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular buffer of fetched instruction entries with flush
module fetch_fifo
  import tessia_fetch_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          resetN,
  input  logic          wrEn,
  input  pf_entry_t     wrData,
  input  logic          rdEn,
  input  logic          flush,
  output logic [CW-1:0] count,
  output pf_entry_t     head
);

  pf_entry_t     mem [DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [CW-1:0] countQ;

  // Pointer and occupancy bookkeeping; flush wins over any write or read this cycle
  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else if (flush) begin
      wrPtr  <= '0;
      rdPtr  <= '0;
      countQ <= '0;
    end else begin
      if (wrEn) wrPtr <= wrPtr + PW'(1);
      if (rdEn) rdPtr <= rdPtr + PW'(1);
      case ({wrEn, rdEn})
        2'b10:   countQ <= countQ + CW'(1);
        2'b01:   countQ <= countQ - CW'(1);
        default: countQ <= countQ;
      endcase
    end
  end

  // Entry storage; contents past the read pointer are never observed, so no reset is needed
  always_ff @(posedge clk) begin
    if (wrEn && !flush) mem[wrPtr] <= wrData;
  end

  assign head  = mem[rdPtr];
  assign count = countQ;

endmodule

// File: rtl/instr_prefetch_queue.sv
// rtl/instr_prefetch_queue.sv - sequential instruction prefetcher feeding the fetch/decode register
module instr_prefetch_queue
  import tessia_fetch_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  input  logic        stall,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic [31:0] instr_pcplus4
);

  localparam int CW = $clog2(DEPTH + 1);

  pf_state_t     state;
  pf_state_t     stateNext;
  logic          reqNext;
  logic [31:0]   addrNext;
  logic [31:0]   fetchPc;
  logic [31:0]   fetchPcNext;
  logic [31:0]   redirectPc;
  logic [CW-1:0] count;
  logic [CW:0]   countNext;
  logic          enq;
  logic          deq;
  logic          credit;
  pf_entry_t     head;
  pf_entry_t     wrEntry;

  // Redirect targets are word aligned regardless of the low address bits supplied
  assign redirectPc = redirect_pc & 32'hFFFF_FFFC;

  assign instr_valid = (count != '0);

  // A redirect squashes both the returning word and the consumer's dequeue
  assign deq = instr_valid & ~stall & ~redirect_valid;
  assign enq = imem_ack & imem_req & (state == WAIT) & ~redirect_valid;

  // Occupancy after this cycle's traffic; a request is only issued if that leaves a free slot,
  // which keeps at most one request outstanding and the buffer from overflowing
  assign countNext = {1'b0, count} + {{CW{1'b0}}, enq} - {{CW{1'b0}}, deq};
  assign credit    = countNext < (CW + 1)'(DEPTH);

  assign wrEntry = '{instr: imem_rdata, pc: imem_addr};

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) uFifo (
    .clk    (clk),
    .resetN (reset),
    .wrEn   (enq),
    .wrData (wrEntry),
    .rdEn   (deq),
    .flush  (redirect_valid),
    .count  (count),
    .head   (head)
  );

  // Request sequencing: choose the next request, address and fetch pointer
  always_comb begin
    stateNext   = state;
    reqNext     = imem_req;
    addrNext    = imem_addr;
    fetchPcNext = fetchPc;
    case (state)
      IDLE: begin
        if (redirect_valid) begin
          reqNext     = 1'b1;
          addrNext    = redirectPc;
          fetchPcNext = redirectPc + PC_STEP;
          stateNext   = WAIT;
        end else if (credit) begin
          reqNext     = 1'b1;
          addrNext    = fetchPc;
          fetchPcNext = fetchPc + PC_STEP;
          stateNext   = WAIT;
        end
      end
      WAIT: begin
        if (imem_ack) begin
          if (redirect_valid) begin
            addrNext    = redirectPc;
            fetchPcNext = redirectPc + PC_STEP;
          end else if (credit) begin
            addrNext    = fetchPc;
            fetchPcNext = fetchPc + PC_STEP;
          end else begin
            reqNext   = 1'b0;
            stateNext = IDLE;
          end
        end else if (redirect_valid) begin
          // The bus cannot retract a request, so remember the target and discard its reply
          fetchPcNext = redirectPc;
          stateNext   = DROP;
        end
      end
      DROP: begin
        if (imem_ack) begin
          stateNext = WAIT;
          if (redirect_valid) begin
            addrNext    = redirectPc;
            fetchPcNext = redirectPc + PC_STEP;
          end else begin
            addrNext    = fetchPc;
            fetchPcNext = fetchPc + PC_STEP;
          end
        end else if (redirect_valid) begin
          fetchPcNext = redirectPc;
        end
      end
      default: begin
        reqNext   = 1'b0;
        stateNext = IDLE;
      end
    endcase
  end

  // Request-side registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      imem_req  <= 1'b0;
      imem_addr <= RESET_PC;
      fetchPc   <= RESET_PC;
    end else begin
      state     <= stateNext;
      imem_req  <= reqNext;
      imem_addr <= addrNext;
      fetchPc   <= fetchPcNext;
    end
  end

  // Head presentation is zeroed while empty so the pipeline sees clean values after reset or flush
  assign instr         = instr_valid ? head.instr : '0;
  assign instr_pc      = instr_valid ? head.pc : '0;
  assign instr_pcplus4 = instr_pc + PC_STEP;

endmodule

// File: tb/tb_instr_prefetch_queue.sv
// tb/tb_instr_prefetch_queue.sv - self-checking bench for instr_prefetch_queue
module tb_instr_prefetch_queue;

  logic        clk = 1'b0;
  logic        reset;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [31:0] instr_pcplus4;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  // Memory model: every word is a fixed function of its address
  assign imem_rdata = imem_addr ^ 32'hA5A5_0000;

  instr_prefetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .stall          (stall),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ack       (imem_ack),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_pcplus4  (instr_pcplus4)
  );

  typedef struct {
    logic        stall;
    logic        ack;
    logic        expReq;
    logic        chkAddr;
    logic [31:0] expAddr;
    logic        expValid;
    logic [31:0] expPc;
  } vec_t;

  vec_t vecs [12];

  function automatic logic [31:0] wordAt(input logic [31:0] pc);
    return pc ^ 32'hA5A5_0000;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chkHead(input string name, input logic [31:0] pc);
    chk({name, "_valid"}, {31'd0, instr_valid}, 32'd1);
    chk({name, "_pc"}, instr_pc, pc);
    chk({name, "_instr"}, instr, wordAt(pc));
    chk({name, "_pcplus4"}, instr_pcplus4, pc + 32'd4);
  endtask

  task automatic chkReset(input string name);
    chk({name, "_req"}, {31'd0, imem_req}, 32'd0);
    chk({name, "_addr"}, imem_addr, 32'h0);
    chk({name, "_valid"}, {31'd0, instr_valid}, 32'd0);
    chk({name, "_instr"}, instr, 32'h0);
    chk({name, "_pc"}, instr_pc, 32'h0);
    chk({name, "_pcplus4"}, instr_pcplus4, 32'h4);
  endtask

  task automatic doReset();
    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_ack       = 1'b0;
    step();
    step();
    reset = 1'b1;
  endtask

  // Random phase reference: the consumer must see consecutive PCs from the last redirect target
  task automatic randomPhase();
    logic [31:0] expPc;
    logic [31:0] prevAddr;
    bit          expectInvalid;
    bit          holdPending;
    int          idleRun;
    int          consumed;
    expPc         = 32'h0;
    expectInvalid = 1'b0;
    holdPending   = 1'b0;
    prevAddr      = 32'h0;
    idleRun       = 0;
    consumed      = 0;
    doReset();
    for (int cyc = 0; cyc < 3000; cyc++) begin
      if (expectInvalid) begin
        chk("rnd_flush_valid", {31'd0, instr_valid}, 32'd0);
      end else if (instr_valid) begin
        chk("rnd_pc", instr_pc, expPc);
        chk("rnd_instr", instr, wordAt(expPc));
        chk("rnd_pcplus4", instr_pcplus4, expPc + 32'd4);
      end
      if (holdPending) begin
        chk("rnd_req_hold", {31'd0, imem_req}, 32'd1);
        chk("rnd_addr_hold", imem_addr, prevAddr);
      end
      chk("rnd_starve", {31'd0, (idleRun <= 60)}, 32'd1);

      stall          = ($urandom_range(0, 9) < 3);
      imem_ack       = ($urandom_range(0, 9) < 6);
      redirect_valid = ($urandom_range(0, 39) == 0);
      redirect_pc    = $urandom_range(0, 1) ? $urandom : (32'hFFFF_FFF0 + 32'($urandom_range(0, 15)));

      holdPending   = imem_req & ~imem_ack;
      prevAddr      = imem_addr;
      expectInvalid = redirect_valid;
      if (redirect_valid) begin
        expPc   = redirect_pc & 32'hFFFF_FFFC;
        idleRun = 0;
      end else if (instr_valid && !stall) begin
        expPc   = expPc + 32'd4;
        consumed++;
        idleRun = 0;
      end else if (!stall) begin
        idleRun++;
      end
      step();
    end
    redirect_valid = 1'b0;
    chk("rnd_progress", {31'd0, (consumed > 300)}, 32'd1);
  endtask

  initial begin
    // Startup sequence from reset, then a stall that fills the queue and a release that drains it
    vecs[0]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h00, 1'b0, 32'h00};
    vecs[1]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h04, 1'b1, 32'h00};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h08, 1'b1, 32'h04};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h0C, 1'b1, 32'h08};
    vecs[4]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h10, 1'b1, 32'h08};
    vecs[5]  = '{1'b1, 1'b1, 1'b1, 1'b1, 32'h14, 1'b1, 32'h08};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    vecs[7]  = '{1'b1, 1'b1, 1'b0, 1'b0, 32'h00, 1'b1, 32'h08};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h18, 1'b1, 32'h0C};
    vecs[9]  = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h1C, 1'b1, 32'h10};
    vecs[10] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h20, 1'b1, 32'h14};
    vecs[11] = '{1'b0, 1'b1, 1'b1, 1'b1, 32'h24, 1'b1, 32'h18};

    reset          = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = 32'h0;
    stall          = 1'b0;
    imem_ack       = 1'b0;
    #1;
    chkReset("reset");
    doReset();
    chkReset("reset_hold");

    for (int i = 0; i < 12; i++) begin
      stall    = vecs[i].stall;
      imem_ack = vecs[i].ack;
      step();
      chk($sformatf("vec%0d_req", i), {31'd0, imem_req}, {31'd0, vecs[i].expReq});
      if (vecs[i].chkAddr) chk($sformatf("vec%0d_addr", i), imem_addr, vecs[i].expAddr);
      chk($sformatf("vec%0d_valid", i), {31'd0, instr_valid}, {31'd0, vecs[i].expValid});
      if (vecs[i].expValid) chkHead($sformatf("vec%0d", i), vecs[i].expPc);
    end

    // Slow memory: request held stable for three cycles, then the queue fills and requests stop
    stall    = 1'b1;
    imem_ack = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("delay_req", {31'd0, imem_req}, 32'd1);
      chk("delay_addr", imem_addr, 32'h24);
    end
    imem_ack = 1'b1;
    step();
    chk("delay_full_req", {31'd0, imem_req}, 32'd0);
    chkHead("delay_head", 32'h18);
    step();
    chk("delay_no_credit_req", {31'd0, imem_req}, 32'd0);

    // Redirect with three entries queued and a request completing in the same cycle
    doReset();
    stall    = 1'b1;
    imem_ack = 1'b1;
    for (int i = 0; i < 4; i++) step();
    chkHead("redir_pre", 32'h0);
    chk("redir_pre_addr", imem_addr, 32'h0C);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h0000_0103;
    step();
    redirect_valid = 1'b0;
    stall          = 1'b0;
    chk("redir_flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("redir_req", {31'd0, imem_req}, 32'd1);
    chk("redir_addr", imem_addr, 32'h100);
    step();
    chkHead("redir_first", 32'h100);
    chk("redir_next_addr", imem_addr, 32'h104);
    step();
    chkHead("redir_second", 32'h104);

    // Redirect while a request is pending: its reply must be discarded
    doReset();
    step();
    chk("drop_req", {31'd0, imem_req}, 32'd1);
    chk("drop_addr0", imem_addr, 32'h0);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h200;
    step();
    redirect_valid = 1'b0;
    chk("drop_hold_addr", imem_addr, 32'h0);
    chk("drop_hold_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chk("drop_hold_addr2", imem_addr, 32'h0);
    imem_ack = 1'b1;
    step();
    chk("drop_reissue_req", {31'd0, imem_req}, 32'd1);
    chk("drop_reissue_addr", imem_addr, 32'h200);
    chk("drop_discard_valid", {31'd0, instr_valid}, 32'd0);
    step();
    chkHead("drop_first", 32'h200);
    chk("drop_next_addr", imem_addr, 32'h204);

    // Address wrap at the top of the space, then reset in the middle of a request
    doReset();
    imem_ack = 1'b1;
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'hFFFF_FFF8;
    step();
    redirect_valid = 1'b0;
    chk("wrap_flush_valid", {31'd0, instr_valid}, 32'd0);
    chk("wrap_addr", imem_addr, 32'hFFFF_FFF8);
    step();
    chkHead("wrap_a", 32'hFFFF_FFF8);
    chk("wrap_addr_b", imem_addr, 32'hFFFF_FFFC);
    step();
    chkHead("wrap_b", 32'hFFFF_FFFC);
    chk("wrap_addr_c", imem_addr, 32'h0);
    step();
    chkHead("wrap_c", 32'h0);
    imem_ack = 1'b0;
    step();
    chk("midreset_pre_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chkReset("midreset");
    imem_ack = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    step();
    chk("stale_ack_valid", {31'd0, instr_valid}, 32'd0);
    chk("stale_ack_req", {31'd0, imem_req}, 32'd1);
    chk("stale_ack_addr", imem_addr, 32'h0);

    randomPhase();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
